// File: rtl/func_arbiter_pkg.sv
// Shared definitions for the function-arbiter fabric.
// Only the return-value width is needed by the child return scheduler.
package func_arbiter_pkg;
    localparam int RET_DW = 32;
endpackage

// File: rtl/ret_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding return entries for one parent.
// Head entry is presented combinationally from the storage array while non-empty.
module ret_sync_fifo #(
    parameter int DW    = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_din,
    input  logic                       i_pop,
    output logic                       o_empty_n,
    output logic [DW-1:0]              o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Pops on an empty FIFO and pushes on a full one are dropped outright.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (r_count < FULL_CNT);

    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty_n = (r_count != '0);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
endmodule

// File: rtl/child_ret_scheduler.sv
// Round-robin scheduler moving child return values into per-parent return FIFOs.
// One child is granted per cycle; children whose destination FIFO is full are skipped.
module child_ret_scheduler
    import func_arbiter_pkg::*;
#(
    parameter int PARENT     = 4,
    parameter int CHILD      = 16,
    parameter int LOG_PARENT = (PARENT == 1) ? 1 : $clog2(PARENT),
    parameter int LOG_CHILD  = (CHILD == 1) ? 1 : $clog2(CHILD),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHILD-1:0]              child_retVld_i,
    input  logic [RET_DW-1:0]             child_retDin_i [CHILD],
    input  logic [LOG_PARENT-1:0]         child_parentMod_i [CHILD],
    output logic [CHILD-1:0]              child_retRdy_o,
    input  logic [PARENT-1:0]             parent_retFifo_pop_i,
    output logic [PARENT-1:0]             parent_retFifo_empty_n_o,
    output logic [RET_DW+LOG_CHILD-1:0]   parent_retFifo_dout_o [PARENT]
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [LOG_CHILD-1:0]  r_rr_ptr;
    logic [CW-1:0]         w_count [PARENT];
    logic [CHILD-1:0]      w_elig;
    logic                  w_found;
    logic [LOG_CHILD-1:0]  w_grant;
    logic [LOG_CHILD-1:0]  w_idx;
    logic [LOG_PARENT-1:0] w_sel_parent;
    logic [RET_DW-1:0]     w_sel_din;

    // Eligibility uses the registered FIFO count, so a same-cycle pop frees no space.
    generate
        for (genvar gi = 0; gi < CHILD; gi++) begin : g_elig
            assign w_elig[gi] = !rst && child_retVld_i[gi]
                                && (int'(child_parentMod_i[gi]) < PARENT)
                                && (w_count[child_parentMod_i[gi]] < FULL_CNT);
            assign child_retRdy_o[gi] = w_found && (w_grant == LOG_CHILD'(gi));
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = r_rr_ptr;
        for (int k = 0; k < CHILD; k++) begin
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
            w_idx = (w_idx == LOG_CHILD'(CHILD - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign w_sel_parent = child_parentMod_i[w_grant];
    assign w_sel_din    = child_retDin_i[w_grant];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_grant == LOG_CHILD'(CHILD - 1)) ? '0 : w_grant + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < PARENT; gi++) begin : g_fifo
            ret_sync_fifo #(
                .DW    (RET_DW + LOG_CHILD),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .i_push    (w_found && (w_sel_parent == LOG_PARENT'(gi))),
                .i_din     ({w_grant, w_sel_din}),
                .i_pop     (parent_retFifo_pop_i[gi]),
                .o_empty_n (parent_retFifo_empty_n_o[gi]),
                .o_dout    (parent_retFifo_dout_o[gi]),
                .o_count   (w_count[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_child_ret_scheduler.sv
// Self-checking bench for child_ret_scheduler: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the grant and FIFO rules.
module tb_child_ret_scheduler;
    localparam int P  = 4;
    localparam int C  = 16;
    localparam int LP = 2;
    localparam int LC = 4;
    localparam int D  = 4;

    typedef logic [35:0] ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [C-1:0]  vld;
    logic [31:0]   din [C];
    logic [LP-1:0] pm [C];
    logic [C-1:0]  rdy;
    logic [P-1:0]  pop;
    logic [P-1:0]  en;
    ent_t          dout [P];

    int   checks   = 0;
    int   failures = 0;
    int   rr       = 0;
    ent_t q [P][$];

    child_ret_scheduler #(
        .PARENT(P), .CHILD(C), .LOG_PARENT(LP), .LOG_CHILD(LC), .FIFO_DEPTH(D)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .child_retVld_i           (vld),
        .child_retDin_i           (din),
        .child_parentMod_i        (pm),
        .child_retRdy_o           (rdy),
        .parent_retFifo_pop_i     (pop),
        .parent_retFifo_empty_n_o (en),
        .parent_retFifo_dout_o    (dout)
    );

    always #5 clk = ~clk;

    // Reference: first requesting child from rr whose destination queue holds fewer than D.
    function automatic int model_grant();
        int c;
        if (rst) return -1;
        for (int k = 0; k < C; k++) begin
            c = (rr + k) % C;
            if (vld[c] && q[pm[c]].size() < D) return c;
        end
        return -1;
    endfunction

    function automatic logic [C-1:0] onehot(int g);
        logic [C-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [P-1:0] model_en();
        logic [P-1:0] v;
        for (int p = 0; p < P; p++) v[p] = (q[p].size() > 0);
        return v;
    endfunction

    task automatic tick();
        int g;
        g = model_grant();
        @(posedge clk);
        if (rst) begin
            for (int p = 0; p < P; p++) q[p].delete();
            rr = 0;
        end else begin
            for (int p = 0; p < P; p++)
                if (pop[p] && q[p].size() > 0) void'(q[p].pop_front());
            if (g >= 0) begin
                q[pm[g]].push_back({4'(g), din[g]});
                rr = (g + 1) % C;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = '0; pop = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = '1; pop = '1;
        #1;
        checks++;
        if (rdy !== '0) begin failures++; $display("FAIL reset_rdy rdy=%h exp=0", rdy); end
        tick(); tick();
        checks++;
        if (en !== '0) begin failures++; $display("FAIL reset_empty_n en=%b exp=0", en); end
        rst = 1'b0; vld = '0; pop = '0;
        $display("test_reset done");
    endtask

    task automatic test_two_children();
        do_reset();
        for (int c = 0; c < C; c++) pm[c] = '0;
        vld = onehot(2) | onehot(5);
        #1;
        checks++;
        if (rdy !== onehot(2)) begin failures++; $display("FAIL two_first rdy=%h exp=%h", rdy, onehot(2)); end
        tick();
        checks++;
        if (rdy !== onehot(5)) begin failures++; $display("FAIL two_second rdy=%h exp=%h", rdy, onehot(5)); end
        tick();
        vld = '0;
        #1;
        checks++;
        if (en[0] !== 1'b1 || dout[0] !== {4'd2, din[2]}) begin
            failures++; $display("FAIL two_head0 en=%b dout=%h exp=%h", en[0], dout[0], {4'd2, din[2]});
        end
        pop = 4'b0001;
        tick();
        checks++;
        if (dout[0] !== {4'd5, din[5]}) begin failures++; $display("FAIL two_head1 dout=%h exp=%h", dout[0], {4'd5, din[5]}); end
        tick();
        pop = '0;
        checks++;
        if (en[0] !== 1'b0) begin failures++; $display("FAIL two_drain en=%b exp=0", en[0]); end
        $display("test_two_children done");
    endtask

    task automatic test_fairness();
        do_reset();
        for (int c = 0; c < C; c++) pm[c] = LP'($urandom_range(0, P-1));
        vld = '1; pop = '1;
        for (int n = 0; n < 40; n++) begin
            #1;
            checks++;
            if (rdy !== onehot(n % C)) begin failures++; $display("FAIL fair_cycle%0d rdy=%h exp=%h", n, rdy, onehot(n % C)); end
            tick();
        end
        vld = '0; pop = '0;
        $display("test_fairness done");
    endtask

    task automatic test_full_skip_and_pop();
        do_reset();
        pm[0] = 2'd1; pm[3] = 2'd1; pm[7] = 2'd2;
        vld = onehot(0);
        for (int n = 0; n < D; n++) begin
            #1;
            checks++;
            if (rdy !== onehot(0)) begin failures++; $display("FAIL fill_cycle%0d rdy=%h exp=%h", n, rdy, onehot(0)); end
            tick();
        end
        vld = onehot(3) | onehot(7);
        #1;
        checks++;
        if (rdy !== onehot(7)) begin failures++; $display("FAIL full_skip rdy=%h exp=%h", rdy, onehot(7)); end
        tick();
        vld = onehot(3);
        #1;
        checks++;
        if (rdy !== '0) begin failures++; $display("FAIL full_block rdy=%h exp=0", rdy); end
        pop = 4'b0010;
        #1;
        checks++;
        if (rdy !== '0) begin failures++; $display("FAIL full_pop_same rdy=%h exp=0", rdy); end
        tick();
        pop = '0;
        #1;
        checks++;
        if (rdy !== onehot(3)) begin failures++; $display("FAIL full_pop_next rdy=%h exp=%h", rdy, onehot(3)); end
        tick();
        #1;
        checks++;
        if (rdy !== '0) begin failures++; $display("FAIL refull rdy=%h exp=0", rdy); end
        vld = '0;
        checks++;
        if (dout[1] !== q[1][0]) begin failures++; $display("FAIL full_head dout=%h exp=%h", dout[1], q[1][0]); end
        $display("test_full_skip_and_pop done");
    endtask

    task automatic test_empty_pop();
        do_reset();
        pop = '1;
        for (int n = 0; n < 3; n++) tick();
        pop = '0;
        checks++;
        if (en !== '0) begin failures++; $display("FAIL empty_pop en=%b exp=0", en); end
        pm[9] = 2'd3; vld = onehot(9);
        tick();
        vld = '0;
        checks++;
        if (en !== 4'b1000 || dout[3] !== {4'd9, din[9]}) begin
            failures++; $display("FAIL empty_push en=%b dout=%h exp=%h", en, dout[3], {4'd9, din[9]});
        end
        pop = 4'b1000;
        tick();
        pop = '0;
        checks++;
        if (en !== '0) begin failures++; $display("FAIL empty_repop en=%b exp=0", en); end
        $display("test_empty_pop done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        pm[1] = 2'd2; pm[2] = 2'd2; pm[3] = 2'd2;
        vld = onehot(1) | onehot(2) | onehot(3);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if (rdy !== '0) begin failures++; $display("FAIL mid_rst_rdy rdy=%h exp=0", rdy); end
        tick();
        rst = 1'b0;
        vld = onehot(10) | onehot(4);
        #1;
        checks++;
        if (en !== '0) begin failures++; $display("FAIL mid_rst_empty en=%b exp=0", en); end
        checks++;
        if (rdy !== onehot(4)) begin failures++; $display("FAIL mid_rst_grant rdy=%h exp=%h", rdy, onehot(4)); end
        tick();
        vld = '0;
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int g;
        logic [P-1:0] een;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            vld = C'($urandom);
            for (int c = 0; c < C; c++) begin
                din[c] = $urandom;
                pm[c]  = LP'($urandom_range(0, P-1));
            end
            pop = P'($urandom & $urandom);
            rst = ($urandom_range(0, 49) == 0);
            #1;
            g = model_grant();
            een = model_en();
            checks++;
            if (rdy !== onehot(g)) begin failures++; $display("FAIL rand_rdy cyc%0d rdy=%h exp=%h", n, rdy, onehot(g)); end
            checks++;
            if (en !== een) begin failures++; $display("FAIL rand_en cyc%0d en=%b exp=%b", n, en, een); end
            for (int p = 0; p < P; p++) begin
                if (q[p].size() > 0) begin
                    checks++;
                    if (dout[p] !== q[p][0]) begin
                        failures++; $display("FAIL rand_dout cyc%0d p%0d dout=%h exp=%h", n, p, dout[p], q[p][0]);
                    end
                end
            end
            tick();
        end
        rst = 1'b0; vld = '0; pop = '0;
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1; vld = '0; pop = '0;
        for (int c = 0; c < C; c++) begin
            din[c] = $urandom;
            pm[c]  = '0;
        end
        test_reset();
        test_two_children();
        test_fairness();
        test_full_skip_and_pop();
        test_empty_pop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
